// File: rtl/seq_divider_12by6.sv
// -----------------------------------------------------------------------------
// seq_divider_12by6
//
// Iterative signed divider paired with the 6x6 signed multiplier. It divides a
// 12-bit signed dividend by a 6-bit signed divisor. The result is a 6-bit
// signed quotient and a 6-bit signed remainder with truncating division, so
// the remainder takes the sign of the dividend.
//
// Operation: a restoring division on magnitudes, one quotient bit per clock.
// The signs are applied in a final FIX cycle.
// Latency: 13 cycles from the accepting edge to results valid.
// Throughput: one result every 14 cycles when start is held high.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      request; sampled only while idle
//   Dividend   [11:0] signed dividend, captured on accept
//   Divisor    [5:0]  signed divisor, captured on accept
//   Quotient   [5:0]  signed quotient, held until next completion
//   Remainder  [5:0]  signed remainder (sign of dividend), held
//   busy       high from the accept edge through the final cycle
//   done       one-cycle completion pulse
//   dbz        divide-by-zero flag for the last result, held
//   ovf        quotient-overflow flag for the last result, held
//
// Configuration macro:
//   DIV_OVF_SAT_EN  When defined, an out-of-range quotient saturates to
//                   +31 or -32 and raises ovf.
//                   When undefined, ovf is tied low and the quotient wraps
//                   to its low 6 bits.
// -----------------------------------------------------------------------------
module seq_divider_12by6 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] Dividend,
  input  logic [5:0]  Divisor,
  output logic [5:0]  Quotient,
  output logic [5:0]  Remainder,
  output logic        busy,
  output logic        done,
  output logic        dbz,
  output logic        ovf
);

`ifdef DIV_OVF_SAT_EN
  // Saturation needs the full quotient magnitude to detect overflow.
  localparam int QW = 12;
`else
  // Wrapping needs only the low 6 quotient bits. After 12 shifts from the
  // LSB, those bits are exactly what a 6-bit shifter holds.
  localparam int QW = 6;
`endif

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t        state;
  logic [11:0]   dvd_sh;    // dividend magnitude, consumed MSB first
  logic [5:0]    dvs_mag;   // divisor magnitude (-32 -> 6'h20 = 32)
  logic [6:0]    pr;        // partial remainder
  logic [3:0]    cnt;       // iteration counter 0..11
  logic [QW-1:0] qmag;      // quotient magnitude, shifted in from the LSB
  logic          sign_q;
  logic          sign_r;
  logic          zero;

  // Two's-complement negation also maps the most-negative value onto its
  // own bit pattern, which reads correctly as an unsigned magnitude.
  logic [11:0] dvd_abs;
  logic [5:0]  dvs_abs;
  assign dvd_abs = Dividend[11] ? (~Dividend + 12'd1) : Dividend;
  assign dvs_abs = Divisor[5]   ? (~Divisor  + 6'd1)  : Divisor;

  // One restoring step. pr stays below |divisor| <= 32, so only pr[5:0]
  // carries information into the shift.
  logic [6:0] pr_sh;
  logic       pr_ge;
  logic [6:0] pr_nxt;
  assign pr_sh  = 7'({pr, dvd_sh[11]});
  assign pr_ge  = (pr_sh >= {1'b0, dvs_mag});
  assign pr_nxt = pr_ge ? (pr_sh - {1'b0, dvs_mag}) : pr_sh;

  logic [5:0] r_signed;
  assign r_signed = sign_r ? (~pr[5:0] + 6'd1) : pr[5:0];

`ifdef DIV_OVF_SAT_EN
  // A negative quotient may reach -32. A positive quotient stops at +31.
  logic q_ovf;
  assign q_ovf = sign_q ? (qmag > 12'd32) : (qmag > 12'd31);
`endif

  logic [5:0] q_final;
  // NOTE: every always_comb output gets a default assignment first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    q_final = sign_q ? (~qmag[5:0] + 6'd1) : qmag[5:0];
`ifdef DIV_OVF_SAT_EN
    if (q_ovf) q_final = sign_q ? 6'h20 : 6'h1F;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only. Every
  // register therefore updates from pre-edge values, whatever the statement
  // order.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: these are plain flops, not a memory, so each one takes an
    // explicit reset value. A reset mid-operation then leaves nothing stale.
    if (rst) begin
      state     <= IDLE;
      dvd_sh    <= '0;
      dvs_mag   <= '0;
      pr        <= '0;
      cnt       <= '0;
      qmag      <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      zero      <= 1'b0;
      Quotient  <= '0;
      Remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dbz       <= 1'b0;
`ifdef DIV_OVF_SAT_EN
      ovf       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd_sh  <= dvd_abs;
            dvs_mag <= dvs_abs;
            sign_q  <= Dividend[11] ^ Divisor[5];
            sign_r  <= Dividend[11];
            zero    <= (Divisor == 6'd0);
            pr      <= '0;
            cnt     <= '0;
            qmag    <= '0;
            busy    <= 1'b1;
            state   <= CALC;
          end
        end
        CALC: begin
          dvd_sh <= {dvd_sh[10:0], 1'b0};
          pr     <= pr_nxt;
          qmag   <= {qmag[QW-2:0], pr_ge};
          cnt    <= cnt + 4'd1;
          if (cnt == 4'd11) state <= FIX;
        end
        FIX: begin
          // A zero divisor still runs the full latency. Only the
          // published result is forced.
          if (zero) begin
            Quotient  <= '0;
            Remainder <= '0;
            dbz       <= 1'b1;
`ifdef DIV_OVF_SAT_EN
            ovf       <= 1'b0;
`endif
          end else begin
            Quotient  <= q_final;
            Remainder <= r_signed;
            dbz       <= 1'b0;
`ifdef DIV_OVF_SAT_EN
            ovf       <= q_ovf;
`endif
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef DIV_OVF_SAT_EN
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider_12by6.sv
// -----------------------------------------------------------------------------
// Testbench for seq_divider_12by6.
//
// A behavioural model tracks the cycles remaining for each operation. It
// computes each result with integer division (/ and %). A compare process
// checks every DUT output against the model on each falling edge. Directed
// transactions also check hand-computed literal results and latencies.
// -----------------------------------------------------------------------------
module tb_seq_divider_12by6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [11:0] dividend = '0;
  logic [5:0]  divisor = '0;
  logic [5:0]  quotient;
  logic [5:0]  remainder;
  logic        busy;
  logic        done;
  logic        dbz;
  logic        ovf;

  int total = 0;
  int bad = 0;
  bit checking = 1'b0;

  seq_divider_12by6 dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .Dividend  (dividend),
    .Divisor   (divisor),
    .Quotient  (quotient),
    .Remainder (remainder),
    .busy      (busy),
    .done      (done),
    .dbz       (dbz),
    .ovf       (ovf)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  function automatic logic [5:0] f_quot(input int a, input int b);
    int q;
    if (b == 0) return 6'h00;
    q = a / b;
`ifdef DIV_OVF_SAT_EN
    if (q > 31)  return 6'h1F;
    if (q < -32) return 6'h20;
`endif
    return q[5:0];
  endfunction

  function automatic logic [5:0] f_rem(input int a, input int b);
    int r;
    if (b == 0) return 6'h00;
    r = a % b;
    return r[5:0];
  endfunction

  function automatic logic f_ovf(input int a, input int b);
`ifdef DIV_OVF_SAT_EN
    int q;
    if (b == 0) return 1'b0;
    q = a / b;
    return (q > 31) || (q < -32);
`else
    return 1'b0 && (a == b);
`endif
  endfunction

  int         m_cnt = 0;   // cycles until the current result is published
  int         m_a = 0;
  int         m_b = 0;
  logic [5:0] m_q = '0;
  logic [5:0] m_r = '0;
  logic       m_done = 1'b0;
  logic       m_dbz = 1'b0;
  logic       m_ovf = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt  <= 0;
      m_q    <= '0;
      m_r    <= '0;
      m_done <= 1'b0;
      m_dbz  <= 1'b0;
      m_ovf  <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt == 0) begin
        if (start) begin
          m_a   <= int'($signed(dividend));
          m_b   <= int'($signed(divisor));
          m_cnt <= 13;
        end
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_q    <= f_quot(m_a, m_b);
          m_r    <= f_rem(m_a, m_b);
          m_dbz  <= (m_b == 0);
          m_ovf  <= f_ovf(m_a, m_b);
          m_done <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("busy", busy, m_cnt != 0);
      check("done", done, m_done);
      check("quotient", quotient, m_q);
      check("remainder", remainder, m_r);
      check("dbz", dbz, m_dbz);
      check("ovf", ovf, m_ovf);
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  // Counts edges until done is seen high; n is capped so the bench never hangs.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < 40);
  endtask

  task automatic run_op(input string name, input logic [11:0] a,
                        input logic [5:0] b, input logic [5:0] eq,
                        input logic [5:0] er, input logic edbz,
                        input logic eovf);
    int n;
    @(posedge clk);
    #1;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);   // E0
    #1;
    start = 1'b0;
    wait_done(n);
    check({name, " latency"}, n, 13);
    check({name, " quotient"}, quotient, eq);
    check({name, " remainder"}, remainder, er);
    check({name, " dbz"}, dbz, edbz);
    check({name, " ovf"}, ovf, eovf);
  endtask

  initial begin
    int n;
    int seen;
    #2 rst = 1'b1;
    @(negedge clk);
    check("reset quotient", quotient, 6'h00);
    check("reset remainder", remainder, 6'h00);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset dbz", dbz, 1'b0);
    check("reset ovf", ovf, 1'b0);
    checking = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;

    run_op("100/7",   12'h064, 6'h07, 6'h0E, 6'h02, 1'b0, 1'b0);
    run_op("-100/7",  12'hF9C, 6'h07, 6'h32, 6'h3E, 1'b0, 1'b0);
    run_op("100/-7",  12'h064, 6'h39, 6'h32, 6'h02, 1'b0, 1'b0);
    run_op("-100/-7", 12'hF9C, 6'h39, 6'h0E, 6'h3E, 1'b0, 1'b0);
`ifdef DIV_OVF_SAT_EN
    run_op("-2048/-1", 12'h800, 6'h3F, 6'h1F, 6'h00, 1'b0, 1'b1);
`else
    run_op("-2048/-1", 12'h800, 6'h3F, 6'h00, 6'h00, 1'b0, 1'b0);
`endif
    run_op("500/0",   12'h1F4, 6'h00, 6'h00, 6'h00, 1'b1, 1'b0);
    run_op("-32/-32", 12'hFE0, 6'h20, 6'h01, 6'h00, 1'b0, 1'b0);

    // Reset at E5 aborts 1000/9.
    @(posedge clk);
    #1;
    dividend = 12'h3E8;
    divisor  = 6'h09;
    start    = 1'b1;
    @(posedge clk);   // E0
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(posedge clk);   // E5
    #1 rst = 1'b1;
    @(negedge clk);
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    check("abort quotient", quotient, 6'h00);
    check("abort remainder", remainder, 6'h00);
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    check("abort no done", seen, 0);
    run_op("63/8", 12'h03F, 6'h08, 6'h07, 6'h07, 1'b0, 1'b0);

    // Start held high, with operands changed after the first accept.
    @(posedge clk);
    #1;
    dividend = 12'h064;
    divisor  = 6'h07;
    start    = 1'b1;
    @(posedge clk);   // E0
    #1;
    dividend = 12'hF9C;
    divisor  = 6'h39;
    wait_done(n);
    check("held first latency", n, 13);
    check("held first quotient", quotient, 6'h0E);
    check("held first remainder", remainder, 6'h02);
    wait_done(n);
    check("held second spacing", n, 14);
    check("held second quotient", quotient, 6'h0E);
    check("held second remainder", remainder, 6'h3E);
    start = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
